// File: rtl/frequency_detect.sv
`default_nettype none
// ============================================================================
// frequency_detect : hysteretic zero-crossing period timer with Hz divider
// Revision         : 1.0
// ============================================================================
module frequency_detect #(
  parameter int width_p    = 12,
  parameter int clk_freq_p = 12_000_000,
  parameter int hyst_p     = 64,
  parameter int timeout_p  = clk_freq_p / 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [15:0]        freq_o,
  output logic               valid_o,
  input  logic               ready_i
);

  localparam int                         cnt_w_lp    = $clog2(timeout_p + 1);
  localparam logic [cnt_w_lp-1:0]        timeout_lp  = cnt_w_lp'(timeout_p);
  localparam logic [cnt_w_lp-1:0]        cnt_one_lp  = cnt_w_lp'(1);
  localparam logic [31:0]                dividend_lp = 32'(clk_freq_p);
  localparam logic signed [width_p-1:0]  hyst_pos_lp = width_p'(hyst_p);
  localparam logic signed [width_p-1:0]  hyst_neg_lp = -hyst_pos_lp;

  typedef enum logic [1:0] {SL_UNKNOWN = 2'd0, SL_LOW = 2'd1, SL_HIGH = 2'd2} slice_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DIV = 2'd1, ST_HOLD = 2'd2} state_e;

  slice_e                slice_q, slice_d;
  state_e                state_q, state_d;
  logic                  ready_q;
  logic                  have_ref_q, have_ref_d;
  logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic [cnt_w_lp-1:0]   req_period_q, req_period_d;
  logic                  pend_v_q, pend_v_d;
  logic [cnt_w_lp-1:0]   pend_period_q, pend_period_d;
  logic [cnt_w_lp-1:0]   divisor_q, divisor_d;
  logic [cnt_w_lp-1:0]   rem_q, rem_d;
  logic [31:0]           quo_q, quo_d;
  logic [5:0]            step_q, step_d;
  logic [15:0]           freq_q, freq_d;
  logic                  valid_q, valid_d;

  logic                  accept, crossing, timeout;
  logic                  load;
  logic [cnt_w_lp-1:0]   load_period;
  logic [cnt_w_lp:0]     rem_sh, div_sub;

  // Slicer, period counter and request generation
  always_comb begin
    accept       = valid_i & ready_q;
    slice_d      = slice_q;
    crossing     = 1'b0;
    if (accept) begin
      if ($signed(data_i) < hyst_neg_lp) begin
        slice_d = SL_LOW;
      end else if (($signed(data_i) > hyst_pos_lp) && (slice_q == SL_LOW)) begin
        slice_d  = SL_HIGH;
        crossing = 1'b1;
      end
    end
    timeout      = have_ref_q && (cnt_q == timeout_lp) && !crossing;
    cnt_d        = cnt_q;
    if (crossing) begin
      cnt_d = cnt_one_lp;
    end else if (cnt_q != timeout_lp) begin
      cnt_d = cnt_q + cnt_one_lp;
    end
    have_ref_d   = have_ref_q;
    req_d        = 1'b0;
    req_period_d = req_period_q;
    if (crossing) begin
      have_ref_d = 1'b1;
      if (have_ref_q) begin
        req_d        = 1'b1;
        req_period_d = cnt_q;
      end
    end else if (timeout) begin
      have_ref_d   = 1'b0;
      req_d        = 1'b1;
      req_period_d = '0;
    end
  end

  // Divider FSM with one-deep newest-wins pending slot
  always_comb begin
    state_d       = state_q;
    divisor_d     = divisor_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    step_d        = step_q;
    freq_d        = freq_q;
    valid_d       = valid_q;
    pend_v_d      = pend_v_q;
    pend_period_d = pend_period_q;
    load          = 1'b0;
    load_period   = pend_period_q;
    rem_sh        = {rem_q, quo_q[31]};
    div_sub       = rem_sh - {1'b0, divisor_q};
    case (state_q)
      ST_IDLE: begin
        if (req_q) begin
          load        = 1'b1;
          load_period = req_period_q;
          pend_v_d    = 1'b0;
        end else if (pend_v_q) begin
          load     = 1'b1;
          pend_v_d = 1'b0;
        end
      end
      ST_DIV: begin
        if (step_q == 6'd32) begin
          state_d = ST_HOLD;
          valid_d = 1'b1;
          freq_d  = (|quo_q[31:16]) ? 16'hFFFF : quo_q[15:0];
        end else begin
          step_d = step_q + 6'd1;
          if (rem_sh >= {1'b0, divisor_q}) begin
            rem_d = div_sub[cnt_w_lp-1:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = rem_sh[cnt_w_lp-1:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
        end
        if (req_q) begin
          pend_v_d      = 1'b1;
          pend_period_d = req_period_q;
        end
      end
      ST_HOLD: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
          if (pend_v_q) begin
            load     = 1'b1;
            pend_v_d = 1'b0;
          end
        end
        // A request landing on the consume cycle refills the slot
        if (req_q) begin
          pend_v_d      = 1'b1;
          pend_period_d = req_period_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      if (load_period == '0) begin
        state_d = ST_HOLD;
        valid_d = 1'b1;
        freq_d  = '0;
      end else begin
        state_d   = ST_DIV;
        valid_d   = 1'b0;
        divisor_d = load_period;
        rem_d     = '0;
        quo_d     = dividend_lp;
        step_d    = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      slice_q       <= SL_UNKNOWN;
      state_q       <= ST_IDLE;
      ready_q       <= 1'b0;
      have_ref_q    <= 1'b0;
      cnt_q         <= '0;
      req_q         <= 1'b0;
      req_period_q  <= '0;
      pend_v_q      <= 1'b0;
      pend_period_q <= '0;
      divisor_q     <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      step_q        <= '0;
      freq_q        <= '0;
      valid_q       <= 1'b0;
    end else begin
      slice_q       <= slice_d;
      state_q       <= state_d;
      ready_q       <= 1'b1;
      have_ref_q    <= have_ref_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      req_period_q  <= req_period_d;
      pend_v_q      <= pend_v_d;
      pend_period_q <= pend_period_d;
      divisor_q     <= divisor_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      step_q        <= step_d;
      freq_q        <= freq_d;
      valid_q       <= valid_d;
    end
  end

  assign ready_o = ready_q;
  assign freq_o  = freq_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_frequency_detect.sv
`default_nettype none
// ============================================================================
// tb_frequency_detect : randomized square-wave stimulus against Hz expectations
// Revision            : 1.0
// ============================================================================
module tb_frequency_detect;

  localparam int W = 12;
  localparam int F = 480_000;
  localparam int H = 64;
  localparam int T = 4000;

  logic         clk = 1'b0;
  logic         reset_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [15:0]  freq_o;
  logic         valid_o;
  logic         ready_i = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int res_q[$];
  int rise_q[$];
  int hold_err = 0;
  logic        prev_v = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [15:0] prev_f = '0;

  frequency_detect #(
    .width_p(W), .clk_freq_p(F), .hyst_p(H), .timeout_p(T)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .freq_o(freq_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  // Output monitor: handshakes, rising edges of valid_o, stability while stalled
  always @(negedge clk) begin
    if (!reset_i) begin
      prev_v = 1'b0;
    end else begin
      if (valid_o && !prev_v) rise_q.push_back(cyc);
      if (valid_o && ready_i) res_q.push_back(int'(freq_o));
      if (prev_v && !prev_rdy && (!valid_o || freq_o != prev_f)) hold_err++;
      prev_v   = valid_o;
      prev_f   = freq_o;
      prev_rdy = ready_i;
    end
  end

  function automatic int exp_freq(input int p);
    int q;
    if (p == 0) return 0;
    q = F / p;
    return (q > 65535) ? 65535 : q;
  endfunction

  task automatic step(input logic [W-1:0] d, input logic v);
    data_i  = d;
    valid_i = v;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // n samples of one polarity with random magnitude beyond the hysteresis;
  // optional invalid gap carrying opposite-polarity garbage
  task automatic half(input int n, input bit pos, input bit gaps, output int first);
    int mag;
    logic [W-1:0] s;
    logic v;
    first = 0;
    for (int i = 0; i < n; i++) begin
      mag = int'($urandom_range(H + 1, 2047));
      s   = pos ? mag[W-1:0] : -mag[W-1:0];
      v   = !(gaps && i >= 200 && i < 300);
      if (!v) s = pos ? -12'sd1000 : 12'sd1000;
      step(s, v);
      if (i == 0) first = cyc;
    end
  endtask

  task automatic noise(input int n);
    int x;
    for (int i = 0; i < n; i++) begin
      x = int'($urandom_range(0, 2 * H)) - H;
      step(x[W-1:0], 1'b1);
    end
  endtask

  task automatic reset_dut();
    reset_i = 1'b0;
    repeat (3) step('0, 1'b0);
    res_q.delete();
    rise_q.delete();
    reset_i = 1'b1;
    step('0, 1'b0);
  endtask

  task automatic check_single(input string name, input int e, input int c2);
    checks++;
    if (res_q.size() != 1) begin
      errors++;
      $display("FAIL %s count: got %0d want 1", name, res_q.size());
    end
    checks++;
    if (res_q.size() == 0 || res_q[0] != e) begin
      errors++;
      $display("FAIL %s freq: got %0d want %0d", name, (res_q.size() != 0) ? res_q[0] : -1, e);
    end
    checks++;
    if (rise_q.size() == 0 || rise_q[0] - c2 != 34) begin
      errors++;
      $display("FAIL %s latency: got %0d want 34", name, (rise_q.size() != 0) ? rise_q[0] - c2 : -1);
    end
  endtask

  task automatic test_reset();
    ready_i = 1'b1;
    step(12'sd1000, 1'b1);
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL reset ready: got %b want 0", ready_o); end
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", valid_o); end
    checks++;
    if (freq_o !== 16'd0) begin errors++; $display("FAIL reset freq: got %0d want 0", freq_o); end
    reset_i = 1'b1;
    step('0, 1'b0);
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL post-reset ready: got %b want 1", ready_o); end
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL post-reset valid: got %b want 0", valid_o); end
  endtask

  task automatic test_measure(input int p, input string name);
    int lo, hi, d, c2;
    reset_dut();
    lo = p / 2;
    hi = p - lo;
    half(lo, 1'b0, 1'b0, d);
    half(hi, 1'b1, 1'b0, d);
    half(lo, 1'b0, 1'b0, d);
    half(hi, 1'b1, 1'b0, c2);
    half(40, 1'b0, 1'b0, d);
    check_single(name, exp_freq(p), c2);
  endtask

  task automatic test_tones();
    int p;
    test_measure(1200, "sq400");
    test_measure(1090, "tone440");
    test_measure(1000, "p1000");
    test_measure(6, "sat6");
    test_measure(8, "p8");
    for (int i = 0; i < 5; i++) begin
      p = int'($urandom_range(8, 1500));
      test_measure(p, "rand");
    end
  endtask

  task automatic test_timeout();
    int d, c2;
    reset_dut();
    half(500, 1'b0, 1'b0, d);
    half(500, 1'b1, 1'b0, d);
    half(500, 1'b0, 1'b0, d);
    half(500, 1'b1, 1'b0, c2);
    half(40, 1'b0, 1'b0, d);
    noise(T + 100);
    checks++;
    if (res_q.size() != 2) begin errors++; $display("FAIL timeout count: got %0d want 2", res_q.size()); end
    checks++;
    if (res_q.size() < 2 || res_q[0] != 480 || res_q[1] != 0) begin
      errors++;
      $display("FAIL timeout values: got %0d,%0d want 480,0",
               (res_q.size() > 0) ? res_q[0] : -1, (res_q.size() > 1) ? res_q[1] : -1);
    end
    checks++;
    if (rise_q.size() < 2 || rise_q[1] - c2 < T - 1 || rise_q[1] - c2 > T + 40) begin
      errors++;
      $display("FAIL timeout timing: got %0d want %0d..%0d",
               (rise_q.size() > 1) ? rise_q[1] - c2 : -1, T - 1, T + 40);
    end
    noise(300);
    half(200, 1'b0, 1'b0, d);
    half(200, 1'b1, 1'b0, d);
    half(50, 1'b0, 1'b0, d);
    checks++;
    if (res_q.size() != 2) begin errors++; $display("FAIL timeout silence: got %0d results want 2", res_q.size()); end
  endtask

  task automatic test_back_to_back();
    int d;
    reset_dut();
    ready_i = 1'b0;
    half(480, 1'b0, 1'b0, d);
    half(480, 1'b1, 1'b0, d);
    half(480, 1'b0, 1'b0, d);
    half(480, 1'b1, 1'b0, d);
    half(480, 1'b0, 1'b0, d);
    half(400, 1'b1, 1'b0, d);
    half(400, 1'b0, 1'b0, d);
    half(40, 1'b1, 1'b0, d);
    half(40, 1'b0, 1'b0, d);
    checks++;
    if (valid_o !== 1'b1 || freq_o !== 16'd500) begin
      errors++;
      $display("FAIL stall hold: got valid=%b freq=%0d want valid=1 freq=500", valid_o, freq_o);
    end
    checks++;
    if (hold_err != 0) begin errors++; $display("FAIL stall stable: got %0d changes want 0", hold_err); end
    checks++;
    if (res_q.size() != 0) begin errors++; $display("FAIL stall leak: got %0d results want 0", res_q.size()); end
    ready_i = 1'b1;
    half(120, 1'b0, 1'b0, d);
    checks++;
    if (res_q.size() != 2 || res_q[0] != 500 || res_q[1] != 600) begin
      errors++;
      $display("FAIL pending newest: got n=%0d first=%0d second=%0d want n=2 500 600", res_q.size(),
               (res_q.size() > 0) ? res_q[0] : -1, (res_q.size() > 1) ? res_q[1] : -1);
    end
  endtask

  task automatic test_gaps();
    int d, c2;
    reset_dut();
    half(600, 1'b0, 1'b1, d);
    half(600, 1'b1, 1'b1, d);
    half(600, 1'b0, 1'b1, d);
    half(600, 1'b1, 1'b1, c2);
    half(40, 1'b0, 1'b0, d);
    check_single("gaps", 400, c2);
  endtask

  task automatic test_reset_mid();
    int d, c2;
    // Mid-HOLD: the held result must vanish without a clock edge
    reset_dut();
    ready_i = 1'b0;
    half(500, 1'b0, 1'b0, d);
    half(500, 1'b1, 1'b0, d);
    half(500, 1'b0, 1'b0, d);
    half(500, 1'b1, 1'b0, d);
    half(40, 1'b0, 1'b0, d);
    reset_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || freq_o !== 16'd0) begin
      errors++;
      $display("FAIL reset hold: got valid=%b freq=%0d want 0 0", valid_o, freq_o);
    end
    ready_i = 1'b1;
    // Mid-DIV, then a leading positive half that UNKNOWN must ignore
    reset_dut();
    half(600, 1'b0, 1'b0, d);
    half(600, 1'b1, 1'b0, d);
    half(600, 1'b0, 1'b0, d);
    half(10, 1'b1, 1'b0, d);
    reset_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || freq_o !== 16'd0) begin
      errors++;
      $display("FAIL reset div: got valid=%b freq=%0d want 0 0", valid_o, freq_o);
    end
    reset_dut();
    half(600, 1'b1, 1'b0, d);
    half(600, 1'b0, 1'b0, d);
    half(600, 1'b1, 1'b0, d);
    half(600, 1'b0, 1'b0, d);
    half(600, 1'b1, 1'b0, c2);
    half(40, 1'b0, 1'b0, d);
    check_single("after-reset", 400, c2);
  endtask

  initial begin
    test_reset();
    test_tones();
    test_timeout();
    test_back_to_back();
    test_gaps();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
